edge_detect_multi: RTL

//   Parametrised multi-channel edge detector: per channel, async input -> synchroniser ->

---
 rtl/edge_detect_pkg.sv | 27 ++
 rtl/edge_detect_chan.sv | 145 ++++++++++++++
 rtl/edge_detect_multi.sv | 42 ++++
 3 files changed

// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector: qualification modes and channel FSM states.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_RISE_PEND = 2'b01,
    ST_HIGH      = 2'b10,
    ST_FALL_PEND = 2'b11
  } chan_state_t;

  function automatic logic qualify(input edge_mode_t m, input logic rise, input logic fall);
    case (m)
      EDGE_RISE: qualify = rise;
      EDGE_FALL: qualify = fall;
      EDGE_BOTH: qualify = rise | fall;
      default:   qualify = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detector channel: synchroniser, level-tracking Mealy FSM, mode qualifier, sticky pending.
// Debounce counter and *_PEND states exist only when EDGE_DEBOUNCE_EN is defined.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       level,
  output logic       evt,
  output logic       pending,
  output logic [1:0] state
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("edge_detect_chan: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  chan_state_t            state_q, state_d;
  logic                   rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt counts consecutive cycles of the new level already seen; it never exceeds CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_HIGH;
            rise    = 1'b1;
          end else begin
            state_d = ST_RISE_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_RISE_PEND: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          rise    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_LOW;
            fall    = 1'b1;
          end else begin
            state_d = ST_FALL_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_FALL_PEND: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          fall    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end
`else
  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          rise    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          fall    = 1'b1;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      level   <= 1'b0;
      pending <= 1'b0;
    end else begin
      state_q <= state_d;
      level   <= (state_d == ST_HIGH) || (state_d == ST_FALL_PEND);
      // A new event wins over a simultaneous clear so it is never lost.
      pending <= evt | (pending & ~clr);
    end
  end

  assign evt   = qualify(mode, rise, fall);
  assign state = state_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top: N_CH independent channels, masked pending OR-ed into irq.
// Optional debounce enabled by defining EDGE_DEBOUNCE_EN. Outputs are level/strobe, no handshake.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [N_CH-1:0]     ien,
  input  logic [N_CH-1:0]     clr,
  output logic [N_CH-1:0]     level,
  output logic [N_CH-1:0]     evt,
  output logic [N_CH-1:0]     pending,
  output logic                irq,
  output logic [2*N_CH-1:0]   dbg_state
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .mode   (edge_mode_t'(mode[2*i+1:2*i])),
      .clr    (clr[i]),
      .level  (level[i]),
      .evt    (evt[i]),
      .pending(pending[i]),
      .state  (dbg_state[2*i+1:2*i])
    );
  end

  assign irq = |(pending & ien);

endmodule
